// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_sequencer
// Description : Drives the PLL reset, qualifies the synchronised lock over a
//               stability window, then releases NUM_CHANNELS reset domains in
//               index order. Lock loss restarts the PLL and is counted.
//               Optional macro PLL_LOCK_TIMEOUT_EN adds a WAIT_LOCK timeout
//               that retries the PLL and sets a sticky lock_timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer #(
    parameter int NUM_CHANNELS        = 4,
    parameter int PLL_RST_CYCLES      = 8,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int STAGGER_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int CNT_W               = 17
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic                    pll_locked,
    input  logic                    sw_reset_req,
    output logic                    pll_rst,
    output logic [NUM_CHANNELS-1:0] chan_rst,
    output logic                    ready,
    output logic [7:0]              lock_loss_cnt,
    output logic [2:0]              state,
    output logic                    lock_timeout
);

    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    localparam logic [CNT_W-1:0] c_pll_rst_last = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_stable_last  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_stagger_last = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] c_last_idx     = IDX_W'(NUM_CHANNELS - 1);

`ifdef PLL_LOCK_TIMEOUT_EN
    localparam logic c_timeout_en = 1'b1;
`else
    localparam logic c_timeout_en = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic                    sync1_q, sync1_d;
    logic                    sync2_q, sync2_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    pll_rst_q, pll_rst_d;
    logic [NUM_CHANNELS-1:0] chan_rst_q, chan_rst_d;
    logic                    ready_q, ready_d;
    logic [7:0]              loss_cnt_q, loss_cnt_d;
    logic                    lock_timeout_q, lock_timeout_d;
    logic                    locked_s;

    assign locked_s = sync2_q;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_PLL_RST;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            cnt_q          <= '0;
            idx_q          <= '0;
            pll_rst_q      <= 1'b1;
            chan_rst_q     <= '1;
            ready_q        <= 1'b0;
            loss_cnt_q     <= 8'd0;
            lock_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            pll_rst_q      <= pll_rst_d;
            chan_rst_q     <= chan_rst_d;
            ready_q        <= ready_d;
            loss_cnt_q     <= loss_cnt_d;
            lock_timeout_q <= lock_timeout_d;
        end
    end

    always_comb begin
        sync1_d        = pll_locked;
        sync2_d        = sync1_q;
        state_d        = state_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        pll_rst_d      = pll_rst_q;
        chan_rst_d     = chan_rst_q;
        ready_d        = ready_q;
        loss_cnt_d     = loss_cnt_q;
        lock_timeout_d = lock_timeout_q;

        case (state_q)
            ST_PLL_RST: begin
                pll_rst_d = 1'b1;
                if (cnt_q == c_pll_rst_last) begin
                    state_d   = ST_WAIT_LOCK;
                    cnt_d     = '0;
                    pll_rst_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (c_timeout_en) begin
                    if (cnt_q == c_timeout_last) begin
                        state_d        = ST_PLL_RST;
                        cnt_d          = '0;
                        pll_rst_d      = 1'b1;
                        lock_timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_STABLE: begin
                // A dropout here only restarts the window; it is not a loss.
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == c_stable_last) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RELEASE, ST_RUN: begin
                if (!locked_s) begin
                    state_d    = ST_PLL_RST;
                    cnt_d      = '0;
                    pll_rst_d  = 1'b1;
                    chan_rst_d = '1;
                    ready_d    = 1'b0;
                    if (loss_cnt_q != 8'hFF) begin
                        loss_cnt_d = loss_cnt_q + 8'd1;
                    end
                end else if (sw_reset_req) begin
                    state_d    = ST_RELEASE;
                    cnt_d      = '0;
                    idx_d      = '0;
                    chan_rst_d = '1;
                    ready_d    = 1'b0;
                end else if (state_q == ST_RELEASE) begin
                    if (cnt_q == c_stagger_last) begin
                        chan_rst_d[idx_q] = 1'b0;
                        cnt_d             = '0;
                        idx_d             = idx_q + 1'b1;
                        if (idx_q == c_last_idx) begin
                            state_d = ST_RUN;
                            ready_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d    = ST_PLL_RST;
                cnt_d      = '0;
                idx_d      = '0;
                pll_rst_d  = 1'b1;
                chan_rst_d = '1;
                ready_d    = 1'b0;
            end
        endcase
    end

    assign pll_rst       = pll_rst_q;
    assign chan_rst      = chan_rst_q;
    assign ready         = ready_q;
    assign lock_loss_cnt = loss_cnt_q;
    assign state         = state_q;
    assign lock_timeout  = lock_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_reset_sequencer
// Description : Randomised scoreboard bench for pll_reset_sequencer against a
//               phase/elapsed-time reference model. Honours PLL_LOCK_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

    localparam int N   = 4;
    localparam int PRC = 8;
    localparam int LSC = 32;
    localparam int STC = 16;
    localparam int LTC = 100;
`ifdef PLL_LOCK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         refclk = 1'b0;
    logic         rst;
    logic         pll_locked;
    logic         sw_reset_req;
    logic         pll_rst;
    logic [N-1:0] chan_rst;
    logic         ready;
    logic [7:0]   lock_loss_cnt;
    logic [2:0]   state;
    logic         lock_timeout;

    pll_reset_sequencer #(
        .NUM_CHANNELS        (N),
        .PLL_RST_CYCLES      (PRC),
        .LOCK_STABLE_CYCLES  (LSC),
        .STAGGER_CYCLES      (STC),
        .LOCK_TIMEOUT_CYCLES (LTC),
        .CNT_W               (17)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .sw_reset_req  (sw_reset_req),
        .pll_rst       (pll_rst),
        .chan_rst      (chan_rst),
        .ready         (ready),
        .lock_loss_cnt (lock_loss_cnt),
        .state         (state),
        .lock_timeout  (lock_timeout)
    );

    always #5 refclk = ~refclk;

    typedef struct packed {
        logic         pll_rst;
        logic [N-1:0] chan;
        logic         ready;
        logic [7:0]   llc;
        logic [2:0]   st;
        logic         to;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: phase number plus edges spent in that phase.
    int m_phase, m_t, m_llc;
    bit m_s1, m_s2, m_to;

    task automatic model_reset();
        m_phase = 0; m_t = 0; m_llc = 0; m_s1 = 0; m_s2 = 0; m_to = 0;
    endtask

    task automatic model_step();
        bit ls;
        if (rst) begin
            model_reset();
            return;
        end
        ls = m_s2;
        case (m_phase)
            0: begin
                m_t++;
                if (m_t == PRC) begin m_phase = 1; m_t = 0; end
            end
            1: begin
                if (ls) begin
                    m_phase = 2; m_t = 0;
                end else if (TO_EN) begin
                    m_t++;
                    if (m_t == LTC) begin m_phase = 0; m_t = 0; m_to = 1; end
                end
            end
            2: begin
                if (!ls) begin
                    m_phase = 1; m_t = 0;
                end else begin
                    m_t++;
                    if (m_t == LSC) begin m_phase = 3; m_t = 0; end
                end
            end
            default: begin
                if (!ls) begin
                    m_phase = 0; m_t = 0;
                    if (m_llc < 255) m_llc++;
                end else if (sw_reset_req) begin
                    m_phase = 3; m_t = 0;
                end else if (m_phase == 3) begin
                    m_t++;
                    if (m_t == N * STC) m_phase = 4;
                end
            end
        endcase
        m_s2 = m_s1;
        m_s1 = pll_locked;
    endtask

    function automatic exp_t model_out();
        exp_t         e;
        logic [N-1:0] all_ones;
        all_ones  = '1;
        e.pll_rst = (m_phase == 0);
        e.ready   = (m_phase == 4);
        e.st      = 3'(m_phase);
        e.llc     = 8'(m_llc);
        e.to      = m_to;
        if (m_phase == 3)      e.chan = all_ones << (m_t / STC);
        else if (m_phase == 4) e.chan = '0;
        else                   e.chan = all_ones;
        return e;
    endfunction

    // One clock: advance the model over the edge just taken, drive the
    // inputs for the next edge, and queue what the DUT should now show.
    task automatic cycle(input logic lk, input logic sw, input logic r);
        @(posedge refclk);
        #2;
        model_step();
        pll_locked   = lk;
        sw_reset_req = sw;
        rst          = r;
        if (r) model_reset();
        exp_q.push_back(model_out());
    endtask

    task automatic hold(input int n, input logic lk, input logic sw);
        for (int i = 0; i < n; i++) cycle(lk, sw, 1'b0);
    endtask

    initial begin : monitor
        exp_t e, a;
        forever begin
            @(negedge refclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {pll_rst, chan_rst, ready, lock_loss_cnt, state, lock_timeout};
                checks++;
                if (a !== e) begin
                    errors++;
                    if (errors <= 20)
                        $display("FAIL outputs t=%0t: got pll_rst=%b chan=%b ready=%b llc=%0d st=%0d to=%b, want pll_rst=%b chan=%b ready=%b llc=%0d st=%0d to=%b",
                                 $time, a.pll_rst, a.chan, a.ready, a.llc, a.st, a.to,
                                 e.pll_rst, e.chan, e.ready, e.llc, e.st, e.to);
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int mode;
        rst = 1'b1; pll_locked = 1'b0; sw_reset_req = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);

        // Cold start: lock at cycle 20, run through release into RUN.
        hold(20, 1'b0, 1'b0);
        hold(150, 1'b1, 1'b0);
        // Software resequence held for 5 cycles.
        hold(5, 1'b1, 1'b1);
        hold(80, 1'b1, 1'b0);
        // Lock loss in RUN, then a glitch inside the stability window.
        hold(3, 1'b0, 1'b0);
        hold(PRC + 2 + 20, 1'b1, 1'b0);
        hold(3, 1'b0, 1'b0);
        hold(120, 1'b1, 1'b0);
        // Async reset mid-RELEASE with two channels released.
        hold(1, 1'b1, 1'b1);
        hold(40, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        // Lock never arrives: timeout retries (or waits forever).
        hold(250, 1'b0, 1'b0);
        // Repeated lock losses drive the counter into saturation.
        for (int k = 0; k < 300; k++) begin
            hold(PRC + LSC + 5, 1'b1, 1'b0);
            hold(3, 1'b0, 1'b0);
        end
        // Randomised segments.
        for (int s = 0; s < 150; s++) begin
            mode = int'($urandom_range(0, 4));
            case (mode)
                0: hold(int'($urandom_range(1, 200)), 1'b1, 1'b0);
                1: hold(int'($urandom_range(1, 8)), 1'b0, 1'b0);
                2: begin
                    hold(int'($urandom_range(1, 6)), 1'b1, 1'b1);
                    hold(int'($urandom_range(1, 100)), 1'b1, 1'b0);
                end
                3: hold(int'($urandom_range(50, 250)), 1'b0, 1'b0);
                default: begin
                    for (int i = 0; i < int'($urandom_range(1, 3)); i++)
                        cycle(1'($urandom_range(0, 1)), 1'b0, 1'b1);
                    cycle(1'b0, 1'b0, 1'b0);
                end
            endcase
        end
        hold(5, 1'b1, 1'b0);
        repeat (3) @(negedge refclk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
